// File: rtl/ctx_mem_arbiter.sv
// Shares one OBI data port between the core LSU and the ctx save/restore streams.
// Grants are held stable until accepted; responses are routed in order by a tag FIFO.
module ctx_mem_arbiter #(
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        ctx_wr_valid_i,
  input  logic [31:0] ctx_wr_addr_i,
  input  logic [31:0] ctx_wr_data_i,
  output logic        ctx_wr_ready_o,
  input  logic        ctx_rd_valid_i,
  input  logic [31:0] ctx_rd_addr_i,
  output logic        ctx_rd_ready_o,
  output logic        ctx_rd_resp_valid_o,
  output logic [31:0] ctx_rd_data_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(MAX_OUTST);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_CORE = 2'd0,
    SRC_WR   = 2'd1,
    SRC_RD   = 2'd2
  } src_e;

  src_e          sel;
  src_e          head;
  src_e          lock_src_q, lock_src_d;
  src_e          tag_q [MAX_OUTST];
  logic          lock_q, lock_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          err_q;
  logic          ctx_pend, force_ctx, sel_vld;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = mem_req_o & mem_gnt_i;
  assign pop   = mem_rvalid_i & ~empty;
  assign head  = tag_q[rptr_q];

  always_comb begin
    ctx_pend  = ctx_wr_valid_i | ctx_rd_valid_i;
    force_ctx = (starve_q == LIMIT) && ctx_pend;
    sel       = SRC_CORE;
    if (lock_q)              sel = lock_src_q;
    else if (force_ctx)      sel = ctx_wr_valid_i ? SRC_WR : SRC_RD;
    else if (core_req_i)     sel = SRC_CORE;
    else if (ctx_wr_valid_i) sel = SRC_WR;
    else if (ctx_rd_valid_i) sel = SRC_RD;
  end

  always_comb begin
    sel_vld     = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (sel)
      SRC_CORE: sel_vld = core_req_i;
      SRC_WR:   sel_vld = ctx_wr_valid_i;
      SRC_RD:   sel_vld = ctx_rd_valid_i;
      default:  sel_vld = 1'b0;
    endcase
    // Reset gating keeps the shared port quiet while rst_ni is low.
    mem_req_o = sel_vld & ~full & rst_ni;
    if (mem_req_o) begin
      case (sel)
        SRC_CORE: begin
          mem_we_o    = core_we_i;
          mem_be_o    = core_be_i;
          mem_addr_o  = core_addr_i;
          mem_wdata_o = core_wdata_i;
        end
        SRC_WR: begin
          mem_we_o    = 1'b1;
          mem_be_o    = 4'hF;
          mem_addr_o  = ctx_wr_addr_i;
          mem_wdata_o = ctx_wr_data_i;
        end
        default: begin
          mem_be_o    = 4'hF;
          mem_addr_o  = ctx_rd_addr_i;
        end
      endcase
    end
  end

  assign core_gnt_o     = push & (sel == SRC_CORE);
  assign ctx_wr_ready_o = push & (sel == SRC_WR);
  assign ctx_rd_ready_o = push & (sel == SRC_RD);

  assign core_rvalid_o       = pop & (head == SRC_CORE);
  assign ctx_rd_resp_valid_o = pop & (head == SRC_RD);
  assign core_rdata_o        = core_rvalid_o ? mem_rdata_i : '0;
  assign ctx_rd_data_o       = ctx_rd_resp_valid_o ? mem_rdata_i : '0;
  assign err_o               = err_q;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (push) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
    starve_d = starve_q;
    if (!ctx_pend)
      starve_d = '0;
    else if (push && sel != SRC_CORE)
      starve_d = '0;
    else if (push && starve_q != LIMIT)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_CORE;
      starve_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) tag_q[i] <= SRC_CORE;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      starve_q   <= starve_d;
      if (push) begin
        tag_q[wptr_q] <= sel;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
      if (mem_rvalid_i && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Randomized bench for ctx_mem_arbiter: an ownership/priority reference model
// checks the issue side each cycle; a scoreboard checks routed responses.
module tb_ctx_mem_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk = 0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ctx_wr_valid_i, ctx_wr_ready_o;
  logic [31:0] ctx_wr_addr_i, ctx_wr_data_i;
  logic        ctx_rd_valid_i, ctx_rd_ready_o;
  logic [31:0] ctx_rd_addr_i;
  logic        ctx_rd_resp_valid_o;
  logic [31:0] ctx_rd_data_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        err_o;

  ctx_mem_arbiter #(.MAX_OUTST(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .ctx_wr_valid_i(ctx_wr_valid_i), .ctx_wr_addr_i(ctx_wr_addr_i),
    .ctx_wr_data_i(ctx_wr_data_i), .ctx_wr_ready_o(ctx_wr_ready_o),
    .ctx_rd_valid_i(ctx_rd_valid_i), .ctx_rd_addr_i(ctx_rd_addr_i),
    .ctx_rd_ready_o(ctx_rd_ready_o),
    .ctx_rd_resp_valid_o(ctx_rd_resp_valid_o), .ctx_rd_data_o(ctx_rd_data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] d;
  } rsp_t;

  rsp_t mq[$];
  rsp_t sb[$];

  int checks = 0;
  int errors = 0;
  int pc, pw, pr, pg, pv;
  bit own_vld, err_m, gC, gW, gR, force_rv;
  int own, starve, run, maxrun;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    if (gC || !core_req_i) begin
      core_req_i   = ($urandom % 100) < pc;
      core_we_i    = $urandom;
      core_be_i    = $urandom;
      core_addr_i  = $urandom;
      core_wdata_i = $urandom;
    end
    if (gW || !ctx_wr_valid_i) begin
      ctx_wr_valid_i = ($urandom % 100) < pw;
      ctx_wr_addr_i  = $urandom;
      ctx_wr_data_i  = $urandom;
    end
    if (gR || !ctx_rd_valid_i) begin
      ctx_rd_valid_i = ($urandom % 100) < pr;
      ctx_rd_addr_i  = $urandom;
    end
    mem_gnt_i = ($urandom % 100) < pg;
    if (force_rv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
    end else if (mq.size() > 0 && ($urandom % 100) < pv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mq[0].d;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  endtask

  // Owner = requester already presented but not yet accepted; otherwise
  // plain priority, with ctx promoted once core has won LIM times in a row.
  task automatic model();
    int src;
    bit sv, ereq, g, pend;
    rsp_t e;
    pend = ctx_wr_valid_i || ctx_rd_valid_i;
    if (own_vld)                 src = own;
    else if (starve == LIM && pend) src = ctx_wr_valid_i ? 1 : 2;
    else if (core_req_i)         src = 0;
    else if (ctx_wr_valid_i)     src = 1;
    else if (ctx_rd_valid_i)     src = 2;
    else                         src = 3;
    sv = (src == 0) ? core_req_i : (src == 1) ? ctx_wr_valid_i :
         (src == 2) ? ctx_rd_valid_i : 1'b0;
    ereq = sv && (mq.size() < DEPTH);
    chk("mem_req", 32'(mem_req_o), 32'(ereq));
    if (ereq) begin
      if (src == 0) begin
        chk("addr_core", mem_addr_o, core_addr_i);
        chk("we_core", 32'(mem_we_o), 32'(core_we_i));
        chk("be_core", 32'(mem_be_o), 32'(core_be_i));
        chk("wdata_core", mem_wdata_o, core_wdata_i);
      end else if (src == 1) begin
        chk("addr_wr", mem_addr_o, ctx_wr_addr_i);
        chk("we_wr", 32'(mem_we_o), 32'd1);
        chk("be_wr", 32'(mem_be_o), 32'hF);
        chk("wdata_wr", mem_wdata_o, ctx_wr_data_i);
      end else begin
        chk("addr_rd", mem_addr_o, ctx_rd_addr_i);
        chk("we_rd", 32'(mem_we_o), 32'd0);
        chk("be_rd", 32'(mem_be_o), 32'hF);
      end
    end
    g = ereq && mem_gnt_i;
    chk("core_gnt", 32'(core_gnt_o), 32'(g && src == 0));
    chk("wr_ready", 32'(ctx_wr_ready_o), 32'(g && src == 1));
    chk("rd_ready", 32'(ctx_rd_ready_o), 32'(g && src == 2));
    chk("err", 32'(err_o), 32'(err_m));
    if (mem_rvalid_i) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else err_m = 1;
    end
    if (g) begin
      e.tag = src;
      e.d   = $urandom;
      mq.push_back(e);
      if (src != 1) sb.push_back(e);
    end
    if (g && src == 0 && pend) run++;
    if (g && src != 0) run = 0;
    if (run > maxrun) maxrun = run;
    if (!pend)                 starve = 0;
    else if (g && src != 0)    starve = 0;
    else if (g && starve < LIM) starve++;
    if (g) own_vld = 0;
    else if (ereq) begin
      own_vld = 1;
      own     = src;
    end
    gC = g && src == 0;
    gW = g && src == 1;
    gR = g && src == 2;
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    if (rst_ni) model();
  endtask

  task automatic phase(int c, int w, int r, int gp, int vp, int n);
    pc = c; pw = w; pr = r; pg = gp; pv = vp;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_model();
    mq.delete();
    sb.delete();
    own_vld = 0; starve = 0; err_m = 0; run = 0;
    gC = 0; gW = 0; gR = 0;
  endtask

  always @(negedge clk) begin
    if (rst_ni && (core_rvalid_o || ctx_rd_resp_valid_o)) begin
      rsp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: core=%b rd=%b expected none at %0t",
                 core_rvalid_o, ctx_rd_resp_valid_o, $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_core_vld", 32'(core_rvalid_o), 32'(e.tag == 0));
        chk("rsp_rd_vld", 32'(ctx_rd_resp_valid_o), 32'(e.tag == 2));
        if (e.tag == 0) chk("rsp_core_data", core_rdata_o, e.d);
        else            chk("rsp_rd_data", ctx_rd_data_o, e.d);
      end
    end
  end

  initial begin
    rst_ni = 0;
    core_req_i = 0; core_we_i = 0; core_be_i = 0;
    core_addr_i = 0; core_wdata_i = 0;
    ctx_wr_valid_i = 0; ctx_wr_addr_i = 0; ctx_wr_data_i = 0;
    ctx_rd_valid_i = 0; ctx_rd_addr_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    force_rv = 0; maxrun = 0;
    clear_model();
    pc = 0; pw = 0; pr = 0; pg = 0; pv = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_core_rv", 32'(core_rvalid_o), 0);
    chk("rst_rd_rv", 32'(ctx_rd_resp_valid_o), 0);
    rst_ni = 1;

    phase(40, 30, 30, 60, 50, 1500);
    maxrun = 0;
    run = 0;
    phase(100, 100, 0, 100, 100, 200);
    chk("starve_run", maxrun, LIM);
    phase(50, 50, 50, 100, 0, 30);
    phase(50, 50, 50, 100, 20, 500);
    phase(0, 0, 0, 100, 100, 60);
    chk("drain_sb", sb.size(), 0);
    chk("drain_mq", mq.size(), 0);

    force_rv = 1;
    step();
    force_rv = 0;
    step();
    chk("err_set", 32'(err_o), 1);
    phase(30, 30, 30, 80, 60, 40);
    chk("err_sticky", 32'(err_o), 1);

    phase(100, 0, 0, 100, 0, 8);
    @(posedge clk);
    #1;
    rst_ni = 0;
    mem_rvalid_i = 0;
    core_req_i = 1;
    clear_model();
    @(negedge clk);
    chk("midrst_req", 32'(mem_req_o), 0);
    chk("midrst_gnt", 32'(core_gnt_o), 0);
    chk("midrst_err", 32'(err_o), 0);
    chk("midrst_rv", 32'(core_rvalid_o), 0);
    core_req_i = 0;
    rst_ni = 1;
    pc = 0; pw = 0; pr = 0;
    force_rv = 1;
    step();
    force_rv = 0;
    step();
    chk("stray_err", 32'(err_o), 1);
    phase(60, 60, 60, 70, 60, 300);
    phase(0, 0, 0, 100, 100, 60);
    chk("final_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
